// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with row synchronizer, press/release debounce
// and one-key encoding (code = row*4 + col) held valid for the whole debounced press.
module keypad_scan #(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CNT = 500_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_m_q, row_s_q;
    logic [1:0]    ci_q, ci_d, ri_q, ri_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] db_q, db_d;
    logic [3:0]    key_value_q, key_value_d;
    logic          key_valid_q, key_valid_d;
    logic          row_hit;
    logic [1:0]    row_low;

    assign row_hit   = row_s_q[ri_q];
    // lowest set row wins when several keys share the driven column
    assign row_low   = row_s_q[0] ? 2'd0 : row_s_q[1] ? 2'd1 : row_s_q[2] ? 2'd2 : 2'd3;
    assign col       = 4'b0001 << ci_q;
    assign key_value = key_value_q;
    assign key_valid = key_valid_q;

    always_comb begin
        state_d     = state_q;
        ci_d        = ci_q;
        ri_d        = ri_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        key_value_d = key_value_q;
        key_valid_d = key_valid_q;
        case (state_q)
            SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (|row_s_q) begin
                        ri_d    = row_low;
                        db_d    = '0;
                        state_d = PRESS_DB;
                    end else begin
                        ci_d = ci_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            PRESS_DB: begin
                if (!row_hit) begin
                    state_d = SCAN;
                    ci_d    = ci_q + 2'd1;
                    dwell_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d     = PRESSED;
                    key_valid_d = 1'b1;
                    key_value_d = {ri_q, ci_q};
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!row_hit) begin
                    state_d = RELEASE_DB;
                    db_d    = '0;
                end
            end
            RELEASE_DB: begin
                if (row_hit) begin
                    state_d = PRESSED;
                end else if (db_q == DB_LAST) begin
                    state_d     = SCAN;
                    ci_d        = ci_q + 2'd1;
                    dwell_d     = '0;
                    key_valid_d = 1'b0;
                    key_value_d = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= SCAN;
            row_m_q     <= '0;
            row_s_q     <= '0;
            ci_q        <= '0;
            ri_q        <= '0;
            dwell_q     <= '0;
            db_q        <= '0;
            key_value_q <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            ci_q        <= ci_d;
            ri_q        <= ri_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad model driving rows from the scanned column; a monitor checks
// each reported press and release against queued expectations and spec timing.
`timescale 1ns/1ps
module tb_keypad_scan;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [3:0]  row, col, key_value;
    logic        key_valid;
    logic [15:0] keys = '0;

    int checks = 0, errors = 0;
    int cyc = 0, run = 0, tc_cyc = -100, e = 0, n = 0;
    logic [3:0] tc_col = '0, pval = '0, pcol = '0;
    logic pv = 1'b0, prst = 1'b1;
    bit armed = 1'b0;
    int exp_code_q[$];
    int exp_fall_q[$];

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk(clk), .reset_p(reset_p), .row(row), .col(col),
        .key_value(key_value), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // key (r,c) connects column c to row r
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // monitor: samples at negedge; cycle index cyc, run = cycles the current column has been driven
    initial forever begin
        @(negedge clk);
        cyc++;
        run = reset_p ? 0 : (col == pcol) ? run + 1 : 1;
        if (armed) begin
            if (key_valid && !pv) begin
                checks++;
                if (exp_code_q.size() == 0) begin
                    errors++;
                    $display("FAIL rise_unexpected key_value=%0d expected no press at cycle %0d", key_value, cyc);
                end else begin
                    e = exp_code_q.pop_front();
                    if (key_value !== 4'(e)) begin
                        errors++;
                        $display("FAIL rise_code got %0d want %0d", key_value, e);
                    end
                    checks++;
                    if (cyc - tc_cyc != DEBOUNCE_CNT + 1) begin
                        errors++;
                        $display("FAIL rise_time got %0d want %0d cycles after detection", cyc - tc_cyc, DEBOUNCE_CNT + 1);
                    end
                end
            end
            if (!key_valid && pv && !prst) begin
                checks++;
                if (exp_fall_q.size() == 0) begin
                    errors++;
                    $display("FAIL fall_unexpected at cycle %0d expected no release", cyc);
                end else begin
                    e = exp_fall_q.pop_front();
                    if (cyc != e) begin
                        errors++;
                        $display("FAIL fall_time got cycle %0d want %0d", cyc, e);
                    end
                end
            end
            if (key_valid && pv) begin
                checks++;
                if (key_value !== pval || col !== pcol) begin
                    errors++;
                    $display("FAIL hold_stable got value=%0d col=%b want value=%0d col=%b", key_value, col, pval, pcol);
                end
            end
            if (!key_valid) begin
                checks++;
                if (key_value !== 4'd0) begin
                    errors++;
                    $display("FAIL idle_value got %0d want 0", key_value);
                end
            end
        end
        if (!reset_p && run == SCAN_DIV) begin
            tc_cyc = cyc;
            tc_col = col;
        end
        pv   = key_valid;
        pval = key_value;
        pcol = col;
        prst = reset_p;
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
        exp_code_q.push_back(r * 4 + c);
    endtask

    // called just after an edge: row_s sees the release 2 cycles later, valid drops D+1 after that
    task automatic release_keys(input logic [15:0] m);
        keys = keys & ~m;
        exp_fall_q.push_back(cyc + 1 + 2 + DEBOUNCE_CNT + 1);
    endtask

    task automatic wait_valid(input logic lvl, input string nm);
        int k = 0;
        while (key_valid !== lvl && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (key_valid !== lvl) begin
            errors++;
            $display("FAIL %s key_valid=%b want %b", nm, key_valid, lvl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    initial begin
        step(2);
        reset_p = 1'b0;
        armed   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            expect_val("reset_scan_col", col, 4'(1 << ((k / 4) % 4)));
        end
        step(1);

        press(0, 3);
        wait_valid(1'b1, "key3_rise");
        expect_val("key3_col_frozen", col, 4'b1000);
        step(200);
        release_keys(16'hffff);
        wait_valid(1'b0, "key3_fall");
        step(20);

        press(2, 2);
        wait_valid(1'b1, "key10_rise");
        step(40);
        release_keys(16'hffff);
        wait_valid(1'b0, "key10_fall");
        step(20);
        press(3, 3);
        wait_valid(1'b1, "key15_rise");
        step(40);
        release_keys(16'hffff);
        wait_valid(1'b0, "key15_fall");
        step(20);

        n = 0;
        while (col !== 4'b0001 && n < 50) begin
            @(negedge clk);
            n++;
        end
        step(1);
        press(0, 2);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            if (tc_cyc == cyc && tc_col == 4'b0100) break;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL bounce_detect got no detection want col 0100 terminal count");
        end
        repeat (3) @(posedge clk);
        #1;
        keys[2] = 1'b0;
        step(1);
        keys[2] = 1'b1;
        wait_valid(1'b1, "key2_rise");
        step(30);
        release_keys(16'hffff);
        wait_valid(1'b0, "key2_fall");
        step(20);

        press(1, 1);
        wait_valid(1'b1, "key5_rise");
        step(10);
        keys[5] = 1'b0;
        step(3);
        keys[5] = 1'b1;
        step(20);
        release_keys(16'hffff);
        wait_valid(1'b0, "key5_fall");
        step(20);

        keys[3]  = 1'b1;
        keys[11] = 1'b1;
        exp_code_q.push_back(3);
        wait_valid(1'b1, "multi_rise");
        step(30);
        release_keys(16'hffff);
        wait_valid(1'b0, "multi_fall");
        step(20);

        press(1, 1);
        wait_valid(1'b1, "lock_rise");
        step(5);
        keys[1] = 1'b1;
        step(20);
        release_keys(16'h0020);
        exp_code_q.push_back(1);
        wait_valid(1'b0, "lock_fall");
        wait_valid(1'b1, "second_rise");
        step(20);
        release_keys(16'hffff);
        wait_valid(1'b0, "second_fall");
        step(20);

        press(1, 3);
        wait_valid(1'b1, "key7_rise");
        step(5);
        exp_code_q.push_back(7);
        reset_p = 1'b1;
        step(1);
        reset_p = 1'b0;
        @(negedge clk);
        expect_val("rst_valid", {3'b000, key_valid}, 4'b0000);
        expect_val("rst_value", key_value, 4'd0);
        expect_val("rst_col", col, 4'b0001);
        step(1);
        wait_valid(1'b1, "key7_rereport");
        step(20);
        release_keys(16'hffff);
        wait_valid(1'b0, "key7_fall");
        step(20);

        for (int i = 0; i < 8; i++) begin
            press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            step(int'($urandom_range(60, 120)));
            release_keys(16'hffff);
            step(int'($urandom_range(25, 60)));
        end

        step(40);
        checks++;
        if (exp_code_q.size() != 0) begin
            errors++;
            $display("FAIL pending_press got %0d unreported want 0", exp_code_q.size());
        end
        checks++;
        if (exp_fall_q.size() != 0) begin
            errors++;
            $display("FAIL pending_release got %0d unreported want 0", exp_fall_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end that produces the `key_value`/`key_valid` pair consumed by the processor's key input port. It drives a 4x4 keypad column by column, synchronizes and debounces the row returns, and encodes one pressed key as a 4-bit code. `key_valid` stays high for the whole debounced press. Codes 0–9 are digits, 10 (`4'ha`) is add, and 15 (`4'hf`) is equals/execute.

## Interface
- `SCAN_DIV`, default 50_000: clock cycles each column is driven (dwell). Legal range ≥ 4.
- `DEBOUNCE_CNT`, default 500_000: consecutive stable cycles required to accept a press or a release. Legal range ≥ 2.
- `clk`  input  1  system clock, single domain.
- `reset_p`  input  1  synchronous, active-high reset.
- `row`  input  4  keypad row returns, active-high (pull-downs on board), asynchronous.
- `col`  output  4  one-hot active-high column drive.
- `key_value`  output  4  code of the accepted key: row_idx*4 + col_idx. Forced to 0 when not valid.
- `key_valid`  output  1  high while a debounced key is held.

## Operation
- `row` passes through a 2-FF synchronizer (`row_s`). All decisions use `row_s` only.
- Column index `ci`: 0..3, with `col = 1 << ci`.
- State machine: SCAN, PRESS_DB, PRESSED, RELEASE_DB.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1. At the terminal count, sample `row_s`.
  - `row_s == 0`: `ci` advances (3 wraps to 0), counter clears.
  - `row_s != 0`: latch `ri` = lowest set bit index of `row_s` (row 0 has priority on multi-key), hold `ci`, go PRESS_DB with the debounce counter at 0.
- PRESS_DB:
  - Each cycle with `row_s[ri] == 1`, the debounce counter increments.
  - When it reaches DEBOUNCE_CNT-1, go PRESSED. Next cycle `key_value` = {ri, ci} and `key_valid` = 1.
  - If `row_s[ri] == 0` on any cycle: abandon, return to SCAN, `ci` advances, dwell counter clears. Outputs unchanged (0).
- PRESSED:
  - `col` held, outputs held. Other keys are ignored.
  - `row_s[ri] == 0` → go RELEASE_DB, debounce counter cleared.
- RELEASE_DB:
  - `key_valid` stays 1 and `key_value` stays unchanged.
  - Each cycle with `row_s[ri] == 0`, the counter increments. At DEBOUNCE_CNT-1, go SCAN. Next cycle `key_valid` = 0 and `key_value` = 0.
  - `ci` advances and the dwell counter clears on that exit.
  - `row_s[ri] == 1` before the count completes → back to PRESSED, with no drop in `key_valid`.
- Only one key is reported per press. A second key held alongside the locked key produces no new code until the locked key is released and scanning resumes.

## Timing
- Reset (synchronous, clocked with `reset_p = 1`) sets:
  - state SCAN, `ci` = 0, `col` = 4'b0001
  - dwell and debounce counters = 0, synchronizer = 0
  - `key_value` = 0, `key_valid` = 0
- Reset asserted in any state overrides everything on that edge. A key still held after reset is re-detected by normal scanning.
- Row-to-decision latency: 2 cycles (synchronizer). SCAN_DIV ≥ 4 guarantees `row_s` reflects the current column at the dwell terminal count.
- Press acceptance: `key_valid` rises exactly DEBOUNCE_CNT+1 cycles after the SCAN terminal-count cycle that detected the key, given a stable press.
- Release: `key_valid` falls exactly DEBOUNCE_CNT+1 cycles after the first cycle with `row_s[ri] == 0`, given a stable release.
- `key_value` changes only on the same edges as `key_valid`. It never changes while `key_valid` = 1.
- Counters are sized with $clog2 of their parameters and never wrap. They saturate/clear by state.

## Test plan
Parameters: SCAN_DIV=4, DEBOUNCE_CNT=8. The bench models the keypad: `row[r]` = `col[c]` while key (r,c) is pressed.
- Reset: `reset_p` = 1 for 2 cycles, then release → `col` = 0001, then 0010 after 4 cycles, 0100, 1000, 0001 cycling. `key_valid` = 0 and `key_value` = 0 throughout.
- Key 3 (r0,c3) held 200 cycles → `key_valid` rises 9 cycles after the detecting terminal count. `key_value` = 3 for the whole pulse. `col` is frozen at 1000 while valid.
- Key 10 (r2,c2) pressed, released, then key 15 (r3,c3) → two separate pulses, `key_value` = 10 then 15. `key_value` = 0 between pulses.
- Bounce: key 2 (r0,c2) asserted 3 cycles after detection, 0 for 1 cycle, then held → first attempt abandoned and scanning continues. The key is accepted on a later scan pass with `key_value` = 2. No glitch on `key_valid`.
- Release bounce: during a held key 5, `row` drops for 3 cycles then returns → `key_valid` stays 1 continuously. It falls only 9 cycles after the final stable release.
- Reset mid-press: `reset_p` pulsed while `key_valid` = 1 → next cycle `key_valid` = 0, `key_value` = 0, `col` = 0001. With the key still held, it is re-reported after re-detection.
